// File: rtl/cosim_compare_sequencer.sv
// rtl/cosim_compare_sequencer.sv - golden-vs-netlist co-sim vector sequencer and result comparator
// Optional build macro: COSIM_FAIL_CAPTURE_EN adds first-failure golden/netlist data capture.
module cosim_compare_sequencer #(
  parameter int DATA_W        = 8,
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDX_W         = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
  parameter int CNT_W         = $clog2(NUM_VECTORS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] golden_data_i,
  input  logic [DATA_W-1:0] netlist_data_i,
  output logic [IDX_W-1:0]  vec_idx_o,
  output logic              vec_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [CNT_W-1:0]  mismatch_count_o,
  output logic [IDX_W-1:0]  first_fail_idx_o,
  output logic              first_fail_valid_o
`ifdef COSIM_FAIL_CAPTURE_EN
  ,
  output logic [DATA_W-1:0] first_fail_golden_o,
  output logic [DATA_W-1:0] first_fail_netlist_o
`endif
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SETTLE_RELOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  vec_idx_q, vec_idx_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]  mm_cnt_q, mm_cnt_d;
  logic [IDX_W-1:0]  ff_idx_q, ff_idx_d;
  logic              ff_valid_q, ff_valid_d;
  logic              pass_q, pass_d;
  logic              vec_valid_q, busy_q, done_q;
  logic              vec_valid_d, busy_d, done_d;
  logic              mismatch;
  logic [CNT_W-1:0]  mm_cnt_inc;

  assign mismatch   = (golden_data_i != netlist_data_i);
  // Saturating increment; the count never wraps back to zero.
  assign mm_cnt_inc = (mm_cnt_q == {CNT_W{1'b1}}) ? mm_cnt_q : mm_cnt_q + 1'b1;

`ifdef COSIM_FAIL_CAPTURE_EN
  logic [DATA_W-1:0] ff_golden_q, ff_golden_d;
  logic [DATA_W-1:0] ff_netlist_q, ff_netlist_d;
`endif

  always_comb begin
    state_d    = state_q;
    vec_idx_d  = vec_idx_q;
    settle_d   = settle_q;
    mm_cnt_d   = mm_cnt_q;
    ff_idx_d   = ff_idx_q;
    ff_valid_d = ff_valid_q;
    pass_d     = pass_q;
`ifdef COSIM_FAIL_CAPTURE_EN
    ff_golden_d  = ff_golden_q;
    ff_netlist_d = ff_netlist_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_SETTLE;
          vec_idx_d  = '0;
          settle_d   = SETTLE_RELOAD;
          mm_cnt_d   = '0;
          ff_valid_d = 1'b0;
          pass_d     = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (settle_q == '0) begin
          state_d = ST_COMPARE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_COMPARE: begin
        // Abort wins: this cycle's comparison is dropped, partial status kept.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          if (mismatch) begin
            mm_cnt_d = mm_cnt_inc;
            if (!ff_valid_q) begin
              ff_idx_d   = vec_idx_q;
              ff_valid_d = 1'b1;
`ifdef COSIM_FAIL_CAPTURE_EN
              ff_golden_d  = golden_data_i;
              ff_netlist_d = netlist_data_i;
`endif
            end
          end
          if (vec_idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            pass_d  = (mm_cnt_d == '0);
          end else begin
            state_d   = ST_SETTLE;
            vec_idx_d = vec_idx_q + 1'b1;
            settle_d  = SETTLE_RELOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so they align with it.
  assign vec_valid_d = (state_d == ST_SETTLE) || (state_d == ST_COMPARE);
  assign busy_d      = vec_valid_d;
  assign done_d      = (state_d == ST_DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      vec_idx_q   <= '0;
      settle_q    <= '0;
      mm_cnt_q    <= '0;
      ff_idx_q    <= '0;
      ff_valid_q  <= 1'b0;
      pass_q      <= 1'b0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      settle_q    <= settle_d;
      mm_cnt_q    <= mm_cnt_d;
      ff_idx_q    <= ff_idx_d;
      ff_valid_q  <= ff_valid_d;
      pass_q      <= pass_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef COSIM_FAIL_CAPTURE_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_golden_q  <= '0;
      ff_netlist_q <= '0;
    end else begin
      ff_golden_q  <= ff_golden_d;
      ff_netlist_q <= ff_netlist_d;
    end
  end

  assign first_fail_golden_o  = ff_golden_q;
  assign first_fail_netlist_o = ff_netlist_q;
`endif

  assign vec_idx_o          = vec_idx_q;
  assign vec_valid_o        = vec_valid_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign mismatch_count_o   = mm_cnt_q;
  assign first_fail_idx_o   = ff_idx_q;
  assign first_fail_valid_o = ff_valid_q;

endmodule
